serial_deserializer: RTL and testbench



---
 rtl/deser_pkg.sv | 22 ++
 rtl/serial_deserializer_if.sv | 43 ++++
 rtl/deser_bit_counter.sv | 44 ++++
 rtl/deser_register.sv | 29 ++
 rtl/serial_deserializer.sv | 127 ++++++++++++
 tb/tb_serial_deserializer.sv | 208 ++++++++++++++++++++
 6 files changed

// File: rtl/deser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : deser_pkg
// Purpose  : Shared state encoding and count-width helper for the deserializer.
// Revision : 1.0 - initial release
// ============================================================================
package deser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_FULL   = 2'd3
    } state_e;

    // bit_count must be able to hold LEN itself while a parity bit is pending
    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_deserializer_if
// Purpose  : Bit-input and word-output handshakes of the deserializer.
//            parity_err exists only when DESER_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_deserializer_if
    import deser_pkg::*;
#(
    parameter int LEN = 32
) ();
    localparam int CW = cnt_width(LEN);

    logic           clear;
    logic           sin;
    logic           sin_valid;
    logic           sin_ready;
    logic [LEN-1:0] data;
    logic           data_valid;
    logic           data_ready;
    logic [CW-1:0]  bit_count;
`ifdef DESER_PARITY_EN
    logic           parity_err;
`endif

    modport slave (
`ifdef DESER_PARITY_EN
        output parity_err,
`endif
        input  clear, sin, sin_valid, data_ready,
        output sin_ready, data, data_valid, bit_count
    );

    modport master (
`ifdef DESER_PARITY_EN
        input  parity_err,
`endif
        output clear, sin, sin_valid, data_ready,
        input  sin_ready, data, data_valid, bit_count
    );
endinterface
`default_nettype wire

// File: rtl/deser_bit_counter.sv
`default_nettype none
// ============================================================================
// Module   : deser_bit_counter
// Purpose  : Load-zero / increment bit counter with terminal flag at LEN-1.
// Revision : 1.0 - initial release
// ============================================================================
module deser_bit_counter
    import deser_pkg::*;
#(
    parameter int LEN = 32
) (
    input  wire logic                      clk,
    input  wire logic                      reset,
    input  wire logic                      load_zero_i,
    input  wire logic                      inc_i,
    output logic [cnt_width(LEN)-1:0]      count_o,
    output logic                           tc_o
);
    localparam int CW = cnt_width(LEN);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_zero_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == CW'(LEN - 1));

endmodule
`default_nettype wire

// File: rtl/deser_register.sv
`default_nettype none
// ============================================================================
// Module   : deser_register
// Purpose  : Plain write-enabled register with synchronous active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module deser_register #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             we_i,
    input  wire logic [WIDTH-1:0] d_i,
    output logic      [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
        end else if (we_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/serial_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : serial_deserializer
// Purpose  : Serial-in/parallel-out receiver with valid/ready on both sides.
//            Define DESER_PARITY_EN to take a trailing even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
module serial_deserializer
    import deser_pkg::*;
#(
    parameter int LEN       = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    serial_deserializer_if.slave  bus
);
    localparam int CW = cnt_width(LEN);

    state_e         state_q, state_d;
    logic [LEN-1:0] shift_q, shift_d;
    logic [CW-1:0]  w_count;
    logic           w_tc;
    logic           w_bit_acc;
    logic           w_word_acc;
    logic           w_enter_full;

    // In FULL a bit may enter only on the edge that also retires the word
    assign bus.sin_ready  = (state_q == ST_FULL) ? bus.data_ready : 1'b1;
    assign bus.data_valid = (state_q == ST_FULL);
    assign bus.bit_count  = w_count;

    assign w_bit_acc    = bus.sin_valid && bus.sin_ready && !bus.clear;
    assign w_word_acc   = bus.data_valid && bus.data_ready;
    assign w_enter_full = (state_d == ST_FULL) && (state_q != ST_FULL);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_bit_acc) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
`ifdef DESER_PARITY_EN
                if (w_bit_acc && w_tc) state_d = ST_PARITY;
`else
                if (w_bit_acc && w_tc) state_d = ST_FULL;
`endif
            end
            ST_PARITY: begin
                if (w_bit_acc) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (w_word_acc) state_d = w_bit_acc ? ST_SHIFT : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bus.clear) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The parity bit is not a data bit, so it never enters the shadow register
    always_comb begin
        shift_d = shift_q;
        if (w_bit_acc && (state_q != ST_PARITY)) begin
            if (MSB_FIRST) begin
                shift_d = {shift_q[LEN-2:0], bus.sin};
            end else begin
                shift_d = {bus.sin, shift_q[LEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    deser_bit_counter #(
        .LEN (LEN)
    ) u_counter (
        .clk         (clk),
        .reset       (reset),
        .load_zero_i (bus.clear || w_enter_full),
        .inc_i       (w_bit_acc),
        .count_o     (w_count),
        .tc_o        (w_tc)
    );

    deser_register #(
        .WIDTH (LEN)
    ) u_word_reg (
        .clk   (clk),
        .reset (reset),
        .we_i  (w_enter_full),
        .d_i   (shift_d),
        .q_o   (bus.data)
    );

`ifdef DESER_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            parity_err_q <= 1'b0;
        end else if (bus.clear || w_word_acc) begin
            parity_err_q <= 1'b0;
        end else if (w_enter_full) begin
            parity_err_q <= (^shift_q) ^ bus.sin;
        end
    end

    assign bus.parity_err = parity_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_deserializer
// Purpose  : Self-checking bench for serial_deserializer (LEN=8, both orders).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_deserializer;
    localparam int LEN = 8;
`ifdef DESER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic reset;

    serial_deserializer_if #(.LEN(LEN)) bm ();
    serial_deserializer_if #(.LEN(LEN)) bl ();

    serial_deserializer #(.LEN(LEN), .MSB_FIRST(1'b1)) u_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (bm.slave)
    );

    serial_deserializer #(.LEN(LEN), .MSB_FIRST(1'b0)) u_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (bl.slave)
    );

    always #5 clk = ~clk;

    int       tests = 0;
    int       fails = 0;
    int       cyc   = 0;
    int       acc_cyc[$];
    bit       q[$];
    bit       full;
    logic [LEN-1:0] held_m, held_l;
    logic     perr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic c, input logic v, input logic s, input logic d);
        reset        = r;
        bm.clear     = c; bl.clear     = c;
        bm.sin_valid = v; bl.sin_valid = v;
        bm.sin       = s; bl.sin       = s;
        bm.data_ready = d; bl.data_ready = d;
    endtask

    // Reference: a word is the list of accepted bits; arrival order decides placement
    task automatic model(input logic r, input logic c, input logic v, input logic s, input logic d);
        bit rdy, bacc, wacc, x;
        if (!r) begin
            q.delete(); full = 0; held_m = '0; held_l = '0; perr = 1'b0;
        end else if (c) begin
            q.delete(); full = 0; perr = 1'b0;
        end else begin
            rdy  = !full || d;
            bacc = v && rdy;
            wacc = full && d;
            if (wacc) begin
                full = 0; perr = 1'b0; acc_cyc.push_back(cyc);
            end
            if (bacc) begin
                if (q.size() == LEN) begin
                    x = s;
                    for (int i = 0; i < LEN; i++) x ^= q[i];
                    perr = x;
                    for (int i = 0; i < LEN; i++) begin
                        held_m[LEN-1-i] = q[i]; held_l[i] = q[i];
                    end
                    full = 1; q.delete();
                end else begin
                    q.push_back(s);
                    if (q.size() == LEN && PAR == 0) begin
                        for (int i = 0; i < LEN; i++) begin
                            held_m[LEN-1-i] = q[i]; held_l[i] = q[i];
                        end
                        full = 1; q.delete();
                    end
                end
            end
        end
    endtask

    task automatic check_outputs(input logic d);
        chk("ready_m", bm.sin_ready, !full || d);
        chk("ready_l", bl.sin_ready, !full || d);
        chk("valid_m", bm.data_valid, full);
        chk("valid_l", bl.data_valid, full);
        chk("count_m", bm.bit_count, q.size());
        chk("count_l", bl.bit_count, q.size());
        chk("data_m", bm.data, held_m);
        chk("data_l", bl.data, held_l);
`ifdef DESER_PARITY_EN
        chk("perr_m", bm.parity_err, perr);
        chk("perr_l", bl.parity_err, perr);
`endif
    endtask

    task automatic step(input logic r, input logic c, input logic v, input logic s, input logic d);
        drive(r, c, v, s, d);
        #1;
        chk("ready_pre", bm.sin_ready, !full || d);
        @(posedge clk);
        cyc++;
        model(r, c, v, s, d);
        #1;
        check_outputs(d);
    endtask

    // Bits go out w[LEN-1] first, followed by the parity bit when enabled
    task automatic send_word(input logic [LEN-1:0] w, input logic pbit, input logic d);
        logic [LEN-1:0] t;
        t = w;
        for (int i = LEN - 1; i >= 0; i--) step(1'b1, 1'b0, 1'b1, t[i], d);
        if (PAR != 0) step(1'b1, 1'b0, 1'b1, pbit, d);
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        model(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_outputs(1'b0);

        // Reset state
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_ready", bm.sin_ready, 1'b1);
        chk("rst_count", bm.bit_count, 0);

        // Bit order: arrival 1,1,0,0,0,0,0,0
        send_word(8'hC0, 1'b0, 1'b0);
        chk("msb_c0", bm.data, 8'hC0);
        chk("lsb_03", bl.data, 8'h03);
        chk("c0_valid", bm.data_valid, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Backpressure on a held word
        send_word(8'hA5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
        chk("bp_data", bm.data, 8'hA5);
        chk("bp_count", bm.bit_count, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Back-to-back streaming
        acc_cyc.delete();
        send_word(8'h12, 1'b1, 1'b1);
        send_word(8'h34, 1'b0, 1'b1);
        send_word(8'h56, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("stream_words", acc_cyc.size(), 3);
        if (acc_cyc.size() == 3) begin
            chk("stream_gap1", acc_cyc[1] - acc_cyc[0], LEN + PAR);
            chk("stream_gap2", acc_cyc[2] - acc_cyc[1], LEN + PAR);
        end

        // Mid-word clear with a bit on the same edge
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("clr_count", bm.bit_count, 0);
        send_word(8'h5A, 1'b0, 1'b0);
        chk("clr_5a", bm.data, 8'h5A);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a word
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mrst_data", bm.data, 0);
        chk("mrst_valid", bm.data_valid, 1'b0);
        chk("mrst_count", bm.bit_count, 0);

`ifdef DESER_PARITY_EN
        send_word(8'h07, 1'b0, 1'b0);
        chk("par_err1", bm.parity_err, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'h07, 1'b1, 1'b0);
        chk("par_err0", bm.parity_err, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        // Random traffic with occasional clear and reset
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 63) != 0),
                 1'($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
